// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and data access.
// Data requests win over fetches; a stalled access is aborted after TIMEOUT cycles with err.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;
  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q, mem_we_q, i_ready_q, d_ready_q, err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, i_rdata_q, d_rdata_q;
  logic        done;
  // an ack on the last allowed cycle still counts as success
  assign done = mem_ack || cnt_q == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: if (d_req || i_req) begin
          state_q     <= d_req ? DACC : IACC;
          cnt_q       <= '0;
          mem_req_q   <= 1'b1;
          mem_we_q    <= d_req && d_we;
          mem_addr_q  <= d_req ? d_addr : i_addr;
          mem_wdata_q <= d_req ? d_wdata : '0;
        end
        IACC, DACC: if (done) begin
          state_q   <= RESP;
          mem_req_q <= 1'b0;
          err_q     <= !mem_ack;
          if (state_q == IACC) begin
            i_ready_q <= 1'b1;
            i_rdata_q <= mem_ack ? mem_rdata : '0;
          end else begin
            d_ready_q <= 1'b1;
            if (!mem_ack || !mem_we_q) d_rdata_q <= mem_ack ? mem_rdata : '0;
          end
        end else cnt_q <= cnt_q + 8'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (TIMEOUT 8 and 4) on shared stimulus, checked every cycle
// against a transaction-level model plus hand-computed literal expectations.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] i_rdata_w [2], d_rdata_w [2], mem_addr_w [2], mem_wdata_w [2];
  logic        i_ready_w [2], d_ready_w [2], mem_req_w [2], mem_we_w [2], err_w [2];
  int          n_chk = 0, n_fail = 0;
  bit          chk_en = 1'b0;
  int          tov [2] = '{8, 4};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.TIMEOUT(g == 0 ? 8 : 4)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata_w[g]), .i_ready(i_ready_w[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata_w[g]), .d_ready(d_ready_w[g]),
      .mem_req(mem_req_w[g]), .mem_we(mem_we_w[g]), .mem_addr(mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err_w[g])
    );
  end

  // transaction model: phase 0 none outstanding, 1 memory busy, 2 responding
  int          m_ph [2], m_age [2];
  bit          m_d [2], m_we [2], m_to [2];
  logic [31:0] m_addr [2], m_wdata [2], m_ir [2], m_dr [2];

  always @(posedge clk or negedge rst) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst) begin
        m_ph[g] <= 0; m_age[g] <= 0; m_d[g] <= 0; m_we[g] <= 0; m_to[g] <= 0;
        m_addr[g] <= '0; m_wdata[g] <= '0; m_ir[g] <= '0; m_dr[g] <= '0;
      end else if (m_ph[g] == 2) m_ph[g] <= 0;
      else if (m_ph[g] == 1) begin
        m_age[g] <= m_age[g] + 1;
        if (mem_ack || m_age[g] + 1 == tov[g]) begin
          m_ph[g] <= 2;
          m_to[g] <= !mem_ack;
          if (!m_d[g]) m_ir[g] <= mem_ack ? mem_rdata : 32'h0;
          else if (!mem_ack || !m_we[g]) m_dr[g] <= mem_ack ? mem_rdata : 32'h0;
        end
      end else if (d_req || i_req) begin
        m_ph[g] <= 1; m_age[g] <= 0; m_d[g] <= d_req; m_we[g] <= d_req && d_we;
        m_addr[g] <= d_req ? d_addr : i_addr;
        m_wdata[g] <= d_req ? d_wdata : 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 2; g++) begin
        logic [132:0] a, e;
        a = {mem_req_w[g], mem_we_w[g], mem_addr_w[g], mem_wdata_w[g], i_ready_w[g],
             d_ready_w[g], err_w[g], i_rdata_w[g], d_rdata_w[g]};
        e = {m_ph[g] == 1, m_we[g], m_addr[g], m_wdata[g], m_ph[g] == 2 && !m_d[g],
             m_ph[g] == 2 && m_d[g], m_ph[g] == 2 && m_to[g], m_ir[g], m_dr[g]};
        n_chk++;
        if (a !== e || (i_ready_w[g] && d_ready_w[g])) begin
          n_fail++;
          $display("FAIL model[%0d] t=%0t: got %h want %h", g, $time, a, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk_en = 1'b1;
    chk("rst_mem_req", 32'(mem_req_w[0]), 0);
    chk("rst_i_rdata", i_rdata_w[0], 0);
    rst = 1'b1;
    step();
    // fetch only, ack in the first busy cycle
    i_req = 1; i_addr = 32'h0040_0000;
    step();
    chk("fetch_req", 32'(mem_req_w[0]), 1);
    chk("fetch_addr", mem_addr_w[0], 32'h0040_0000);
    mem_ack = 1; mem_rdata = 32'h8C01_0004;
    step();
    mem_ack = 0;
    chk("fetch_ready", 32'(i_ready_w[0]), 1);
    chk("fetch_rdata", i_rdata_w[0], 32'h8C01_0004);
    i_req = 0;
    step();
    chk("fetch_ready_pulse", 32'(i_ready_w[0]), 0);
    // both pending: store first, then fetch
    i_req = 1; i_addr = 32'h0040_0004;
    d_req = 1; d_we = 1; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("both_we", 32'(mem_we_w[0]), 1);
    chk("both_addr", mem_addr_w[0], 32'h1001_0000);
    chk("both_wdata", mem_wdata_w[0], 32'hDEAD_BEEF);
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    step();
    mem_ack = 0;
    chk("both_d_ready", 32'(d_ready_w[0]), 1);
    chk("both_i_ready_low", 32'(i_ready_w[0]), 0);
    chk("store_keeps_d_rdata", d_rdata_w[0], 0);
    d_req = 0; d_we = 0;
    step();
    step();
    chk("fetch2_addr", mem_addr_w[0], 32'h0040_0004);
    chk("fetch2_we", 32'(mem_we_w[0]), 0);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 0;
    chk("fetch2_rdata", i_rdata_w[0], 32'h1234_5678);
    i_req = 0;
    step();
    // five wait states on a load
    d_req = 1; d_addr = 32'h1001_0040;
    step();
    for (int k = 1; k <= 5; k++) begin
      chk("wait_req", 32'(mem_req_w[0]), 1);
      chk("wait_addr", mem_addr_w[0], 32'h1001_0040);
      if (k == 5) begin mem_ack = 1; mem_rdata = 32'hCAFE_F00D; end
      step();
    end
    mem_ack = 0;
    chk("wait_ready", 32'(d_ready_w[0]), 1);
    chk("wait_rdata", d_rdata_w[0], 32'hCAFE_F00D);
    chk("wait_err", 32'(err_w[0]), 0);
    d_req = 0;
    step();
    chk("wait_ready_pulse", 32'(d_ready_w[0]), 0);
    // no ack: TIMEOUT=4 aborts after 4 busy cycles, TIMEOUT=8 after 8
    d_req = 1; d_addr = 32'h1001_0080;
    step();
    for (int k = 1; k <= 4; k++) begin
      chk("to4_req", 32'(mem_req_w[1]), 1);
      step();
    end
    chk("to4_req_drop", 32'(mem_req_w[1]), 0);
    chk("to4_ready", 32'(d_ready_w[1]), 1);
    chk("to4_err", 32'(err_w[1]), 1);
    chk("to4_rdata", d_rdata_w[1], 0);
    d_req = 0;
    step(); step(); step(); step();
    chk("to8_err", 32'(err_w[0]), 1);
    chk("to8_rdata_zeroed", d_rdata_w[0], 0);
    step();
    // ack in the final allowed cycle wins over the timeout
    d_req = 1; d_addr = 32'h1001_00C0;
    step(); step(); step(); step();
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 0;
    chk("late_ack_ready", 32'(d_ready_w[1]), 1);
    chk("late_ack_err", 32'(err_w[1]), 0);
    chk("late_ack_rdata", d_rdata_w[1], 32'h0BAD_F00D);
    d_req = 0;
    step();
    // requester drops i_req mid-transaction
    i_req = 1; i_addr = 32'h0040_0020;
    step();
    i_req = 0;
    step();
    mem_ack = 1; mem_rdata = 32'h55AA_55AA;
    step();
    mem_ack = 0;
    chk("drop_ready", 32'(i_ready_w[0]), 1);
    chk("drop_rdata", i_rdata_w[0], 32'h55AA_55AA);
    step();
    // reset in the middle of a store
    d_req = 1; d_we = 1; d_addr = 32'h1001_0100; d_wdata = 32'h1111_1111;
    step();
    chk("rst_mid_req", 32'(mem_req_w[0]), 1);
    #2 rst = 0;
    #1;
    chk("rst_async_req", 32'(mem_req_w[0]), 0);
    chk("rst_async_addr", mem_addr_w[0], 0);
    d_req = 0; d_we = 0;
    step();
    chk("rst_no_ready", 32'(d_ready_w[0]), 0);
    step();
    rst = 1;
    i_req = 1; i_addr = 32'h0040_0010;
    step();
    chk("post_rst_req", 32'(mem_req_w[0]), 1);
    chk("post_rst_addr", mem_addr_w[0], 32'h0040_0010);
    mem_ack = 1; mem_rdata = 32'h2402_0005;
    step();
    mem_ack = 0;
    chk("post_rst_ready", 32'(i_ready_w[0]), 1);
    chk("post_rst_rdata", i_rdata_w[0], 32'h2402_0005);
    i_req = 0;
    step();
    // spurious ack while idle
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 0;
    chk("spur_i_ready", 32'(i_ready_w[0]), 0);
    chk("spur_d_ready", 32'(d_ready_w[0]), 0);
    chk("spur_req", 32'(mem_req_w[0]), 0);
    chk("spur_i_rdata", i_rdata_w[0], 32'h2402_0005);
    step();
    chk("spur_req_after", 32'(mem_req_w[0]), 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
